// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Results are computed at issue and held in a
// pending register, then committed to HI/LO after a fixed per-class latency.
module e_mdu #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out
);
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   pend;
  logic [2*WIDTH-1:0]   prod_u, prod_s, acc, res;
  logic [WIDTH-1:0]     dvs, q_u, r_u, q_s, r_s;
  logic                 div_zero, div_ovf, is_mul, is_div;

  assign busy = (cnt != '0);
  assign acc  = {hi, lo};

  assign prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
  assign prod_s = $signed({{WIDTH{rs[WIDTH-1]}}, rs}) * $signed({{WIDTH{rt[WIDTH-1]}}, rt});

  // Divisor is forced to 1 in the special cases so the divider never sees
  // x/0 or MIN/-1; those results are substituted below.
  assign div_zero = (rt == '0);
  assign div_ovf  = (rs == {1'b1, {(WIDTH-1){1'b0}}}) && (rt == {WIDTH{1'b1}});
  assign dvs      = (div_zero || div_ovf) ? WIDTH'(1) : rt;
  assign q_u      = rs / dvs;
  assign r_u      = rs % dvs;
  assign q_s      = $signed(rs) / $signed(dvs);
  assign r_s      = $signed(rs) % $signed(dvs);

  always_comb begin
    res    = '0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (op)
      OP_MULT:  begin is_mul = 1'b1; res = prod_s;       end
      OP_MULTU: begin is_mul = 1'b1; res = prod_u;       end
      OP_MADD:  begin is_mul = 1'b1; res = acc + prod_s; end
      OP_MADDU: begin is_mul = 1'b1; res = acc + prod_u; end
      OP_MSUB:  begin is_mul = 1'b1; res = acc - prod_s; end
      OP_MSUBU: begin is_mul = 1'b1; res = acc - prod_u; end
      OP_DIV: begin
        is_div = 1'b1;
        if (div_zero)     res = {rs, {WIDTH{1'b1}}};
        else if (div_ovf) res = {{WIDTH{1'b0}}, rs};
        else              res = {r_s, q_s};
      end
      OP_DIVU: begin
        is_div = 1'b1;
        if (div_zero) res = {rs, {WIDTH{1'b1}}};
        else          res = {r_u, q_u};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      pend <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (flush) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          {hi, lo} <= pend;
          done     <= 1'b1;
        end
      end else if (start) begin
        if (is_mul || is_div) begin
          pend <= res;
          cnt  <= is_div ? DIV_CNT : MULT_CNT;
        end else if (op == OP_MTHI) begin
          hi <= rs;
        end else if (op == OP_MTLO) begin
          lo <= rs;
        end
      end
    end
  end

  always_comb begin
    out = '0;
    if (op == OP_MFHI)      out = hi;
    else if (op == OP_MFLO) out = lo;
  end
endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed table, multi-cycle corner sequences and random
// ops checked against an arithmetic model of HI/LO.
module tb_e_mdu;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  localparam logic [3:0] MULT = 1, MULTU = 2, DIV = 3, DIVU = 4, MTHI = 5, MTLO = 6,
                         MADD = 7, MADDU = 8, MSUB = 9, MSUBU = 10, MFHI = 11, MFLO = 12;

  logic clk = 1'b0;
  logic reset, start, flush;
  logic [3:0] op;
  logic [W-1:0] rs, rt;
  logic busy, done;
  logic [W-1:0] hi, lo, out;

  e_mdu #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .out(out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, hi0, lo0, ehi, elo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, division via magnitudes and signs.
  task automatic ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, ma, mb, q, r;
    logic [63:0] prod, acc;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    acc = {m_hi, m_lo};
    case (o)
      MULT, MADD, MSUB: prod = 64'(sa * sb);
      default:          prod = 64'(ua * ub);
    endcase
    case (o)
      MULT, MULTU:  {m_hi, m_lo} = prod;
      MADD, MADDU:  {m_hi, m_lo} = acc + prod;
      MSUB, MSUBU:  {m_hi, m_lo} = acc - prod;
      DIV, DIVU: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else if (o == DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = a; m_hi = 0;
        end else if (o == DIVU) begin
          m_lo = 32'(ua / ub); m_hi = 32'(ua % ub);
        end else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb; r = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          m_lo = 32'(q); m_hi = 32'(r);
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_move(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1; op = o; rs = v; rt = 0;
    if (o == MTHI) m_hi = v; else m_lo = v;
    @(negedge clk);
    start = 0; op = 0;
    check("move_busy", busy, 0);
    check("move_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic do_arith(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string name);
    int lat;
    bit bad;
    lat = (o == DIV || o == DIVU) ? DL : ML;
    ref_op(o, a, b);
    @(negedge clk);
    start = 1; op = o; rs = a; rt = b;
    bad = 0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      start = 0; op = 0;
      if (busy !== 1'b1 || done !== 1'b0) bad = 1;
    end
    check({name, "_busywin"}, bad, 0);
    @(negedge clk);
    check({name, "_done"}, {done, busy}, 2'b10);
    check({name, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[$];
  logic [3:0] rops[10] = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU};

  initial begin
    bit bad;
    logic [3:0] o;
    logic [31:0] a, b, sh, sl;

    vecs.push_back('{MULT,  32'hFFFF_FFFF, 2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{MULTU, 32'hFFFF_FFFF, 2, 0, 0, 32'h1,         32'hFFFF_FFFE});
    vecs.push_back('{DIV,   32'hFFFF_FFF9, 2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{DIVU,  7, 0, 0, 0, 7, 32'hFFFF_FFFF});
    vecs.push_back('{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 32'h8000_0000});
    vecs.push_back('{MADD,  1, 1, 0, 32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{MSUBU, 1, 2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{DIV,   7, 0, 0, 0, 7, 32'hFFFF_FFFF});
    vecs.push_back('{MSUB,  2, 3, 0, 10, 0, 4});
    vecs.push_back('{MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF, 2});
    vecs.push_back('{DIV,   7, 32'hFFFF_FFFE, 0, 0, 1, 32'hFFFF_FFFD});

    reset = 0; start = 0; flush = 0; op = MFHI; rs = 0; rt = 0;
    #12;
    check("rst_state", {busy, done, hi, lo, out}, 0);
    @(negedge clk);
    reset = 1; op = 0;

    foreach (vecs[i]) begin
      do_move(MTHI, vecs[i].hi0);
      do_move(MTLO, vecs[i].lo0);
      do_arith(vecs[i].op, vecs[i].rs, vecs[i].rt, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_table", i), {hi, lo}, {vecs[i].ehi, vecs[i].elo});
      @(negedge clk);
      check($sformatf("vec%0d_donepulse", i), done, 0);
    end

    op = MFLO; #1;
    check("mflo_out", out, m_lo);
    op = 0;

    // Flush in the 3rd busy cycle of a divide.
    sh = m_hi; sl = m_lo;
    @(negedge clk); start = 1; op = DIV; rs = 100; rt = 7;
    @(negedge clk); start = 0; op = 0;
    @(negedge clk);
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    check("flush_busy", {busy, done}, 0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    check("flush_nodone", bad, 0);
    check("flush_hilo", {hi, lo}, {sh, sl});

    // start together with flush is dropped.
    @(negedge clk); start = 1; flush = 1; op = MULT; rs = 3; rt = 3;
    @(negedge clk); start = 0; flush = 0; op = 0;
    check("startflush_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < ML + 2; i++) begin
      @(negedge clk);
      if (done !== 1'b0) bad = 1;
    end
    check("startflush_nodone", bad, 0);
    check("startflush_hilo", {hi, lo}, {sh, sl});

    // mthi during a busy mult is ignored; mfhi in the done cycle sees new HI.
    ref_op(MULT, 32'h10, 32'h2000_0000);
    @(negedge clk); start = 1; op = MULT; rs = 32'h10; rt = 32'h2000_0000;
    @(negedge clk); start = 0; op = 0;
    @(negedge clk); start = 1; op = MTHI; rs = 32'h1234;
    @(negedge clk); start = 0; op = 0;
    for (int i = 4; i <= ML; i++) @(negedge clk);
    @(negedge clk); op = MFHI; #1;
    check("guard_done", done, 1);
    check("guard_out", out, m_hi);
    check("guard_hi", {hi, lo}, {32'h2, 32'h0});
    op = 0; #1;
    check("out_none", out, 0);

    for (int n = 0; n < 60; n++) begin
      o = rops[$urandom_range(0, 9)];
      a = rnd_operand();
      b = rnd_operand();
      if (o == MTHI || o == MTLO) do_move(o, a);
      else do_arith(o, a, b, $sformatf("rnd%0d_op%0d", n, o));
    end

    // Asynchronous reset while a divide has CNT=4.
    do_move(MTHI, 32'hA5A5_0001);
    @(negedge clk); start = 1; op = DIV; rs = 50; rt = 3;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); start = 0; op = 0;
    end
    #2 reset = 0;
    #1 check("midrst_state", {busy, done, hi, lo}, 0);
    @(negedge clk); reset = 1;
    m_hi = 0; m_lo = 0;
    bad = 0;
    for (int i = 0; i < DL + 2; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1;
    end
    check("postrst_idle", bad, 0);
    check("postrst_hilo", {hi, lo}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multiply/divide unit for the E stage, replacing the fixed-latency HI/LO block. It accepts one multiply, divide, multiply-accumulate or HI/LO move per issue, holds a `busy` flag while an operation is in flight, and commits results to architectural HI/LO registers after a configurable latency. It adds accumulate operations, defined divide-by-zero and overflow results, a pipeline flush input, and a completion pulse. The stall unit consumes `busy` and `start`.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_LAT`, 5: cycles from issue to commit for mult, multu, madd, maddu, msub and msubu. Must be ≥1.
- `DIV_LAT`, 10: cycles from issue to commit for div and divu. Must be ≥1.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: issue strobe; `op` is valid this cycle.
- `op` input 4: operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11 mfhi, 12 mflo. Codes 13–15 are no-ops.
- `rs` input WIDTH: first operand (forwarded value).
- `rt` input WIDTH: second operand (forwarded value).
- `flush` input 1: abort the in-flight operation and discard the current issue.
- `busy` output 1: an operation is in flight.
- `done` output 1: one-cycle pulse; new HI/LO values become visible this cycle.
- `hi` output WIDTH: architectural HI.
- `lo` output WIDTH: architectural LO.
- `out` output WIDTH: combinational read port. Equals `hi` when `op`=mfhi, `lo` when `op`=mflo, else 0. It is independent of `start` and `busy`.

## Operation
- State:
  - HI and LO registers.
  - Pending result registers P_HI and P_LO.
  - Down-counter CNT, wide enough for max(MULT_LAT, DIV_LAT).
  - `done` register.
- `busy` = (CNT != 0), combinational from CNT.
- Issue is accepted when `start`=1, `busy`=0 and `flush`=0.
  - If `start`=1 while `busy`=1, the issue is ignored and there is no state change. The stall unit must prevent this.
- Arithmetic ops are evaluated at issue from `rs`, `rt` and the current HI/LO. The result goes to P_HI/P_LO, and CNT loads MULT_LAT or DIV_LAT.
  - mult/multu: {P_HI,P_LO} = signed/unsigned 2·WIDTH product.
  - madd/maddu: {P_HI,P_LO} = {HI,LO} + product, modulo 2^(2·WIDTH).
  - msub/msubu: {P_HI,P_LO} = {HI,LO} − product, modulo 2^(2·WIDTH).
  - div/divu: P_LO = quotient truncated toward zero, P_HI = remainder with the sign of the dividend.
  - Divide by zero (either signedness): P_LO = all ones, P_HI = `rs`.
  - Signed overflow (rs = −2^(WIDTH−1), rt = −1): P_LO = `rs`, P_HI = 0.
- mthi/mtlo: HI or LO is written with `rs` at the issue edge. CNT stays 0 and `done` is not asserted.
- mfhi/mflo/none: no state change.
- Each edge with CNT ≠ 0 decrements CNT. At the edge where CNT goes 1→0, HI/LO ← P_HI/P_LO and `done` is set for one cycle.
- `flush`=1 at an edge:
  - CNT ← 0 and `done` ← 0.
  - HI/LO are unchanged and the pending result is discarded.
  - A simultaneous `start` is ignored: flush wins.
  - If flush coincides with the commit edge (CNT=1), flush still wins and no commit occurs.
- Reset low, at any time including mid-operation: HI=LO=0, P_HI=P_LO=0, CNT=0, `done`=0, asynchronously. `busy`=0 while reset is low.

## Timing
- Issue accepted at edge of cycle t.
  - `busy`=1 in cycles t+1 through t+LAT.
  - New HI/LO are visible and `done`=1 in cycle t+LAT+1.
  - `busy`=0 in cycle t+LAT+1.
- A new issue is accepted in cycle t+LAT+1. Back-to-back ops therefore have an issue interval of LAT+1 cycles.
- mthi/mtlo issued at edge t: the value is visible on `hi`/`lo` in cycle t+1, with `busy` never asserted.
- `out` has zero latency. An mfhi in cycle t+LAT+1 returns the new HI.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `out`=0 (unless op is mfhi/mflo, which reads 0 anyway).

## Test plan
Defaults: WIDTH=32, MULT_LAT=5, DIV_LAT=10.
- **Reset:** assert `reset`=0 mid-div (CNT=4) → `busy`, `done`, `hi`, `lo` are all 0 immediately. After release, `busy` stays 0.
- **Multiply:** mult rs=0xFFFFFFFF, rt=2 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE with `done` for 1 cycle. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- **Divide:**
  - div rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/0 → LO=0xFFFFFFFF, HI=7.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Accumulate:**
  - mtlo 0xFFFFFFFF then madd rs=1, rt=1 → HI=1, LO=0.
  - msubu rs=1, rt=2 from HI=LO=0 → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- **Flush:** issue div, assert `flush` in the 3rd busy cycle → `busy`=0 next cycle, HI/LO unchanged, no `done`. A `start`+`flush` issue of mult in the same cycle is ignored.
- **Busy guard:** mthi 0x1234 issued while a mult is busy → ignored, HI reflects only the mult result. An mfhi in the `done` cycle returns the new HI on `out`.
